// File: rtl/sd_byte_feeder_if.sv
// rtl/sd_byte_feeder_if.sv - producer stream and SD-writer handshake bundle for sd_byte_feeder
interface sd_byte_feeder_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        sd_init_finish;
    logic [7:0]  fo_data;
    logic        fo_start;
    logic        fo_finish;
    logic        busy;
    logic        overflow;
    logic [15:0] block_count;

    // master: the feeder itself, which initiates fo_start transfers
    modport master (
        input  in_data, in_valid, flush, sd_init_finish, fo_finish,
        output in_ready, fo_data, fo_start, busy, overflow, block_count
    );

    // slave: producer plus SD writer surrounding the feeder
    modport slave (
        output in_data, in_valid, flush, sd_init_finish, fo_finish,
        input  in_ready, fo_data, fo_start, busy, overflow, block_count
    );
endinterface

// File: rtl/sd_byte_feeder.sv
// rtl/sd_byte_feeder.sv - byte FIFO feeding the SD block writer over a 4-phase fo_start/fo_finish handshake
module sd_byte_feeder #(
    parameter int         DEPTH      = 16,
    parameter logic [7:0] END_TOKEN  = 8'h2D,
    parameter int         BLOCK_MAX  = 511,
    parameter int         GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    sd_byte_feeder_if.master bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [8:0]       BLK_LAST = 9'(BLOCK_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        REL  = 2'd3
    } stateType;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wrPtr;
    logic [ADDR_W-1:0] rdPtr;
    logic [CNT_W-1:0]  count;
    logic              flushPend;
    logic              overflowReg;

    stateType          state;
    logic [GAP_W-1:0]  gapCnt;
    logic [8:0]        blkIdx;
    logic [15:0]       blockCount;
    logic [7:0]        foData;
    logic              foStart;

    logic              notFull;
    logic              dataPush;
    logic              tokenPush;
    logic              doPush;
    logic              doPop;
    logic [7:0]        pushByte;

    // A pending flush closes the input so the token is the next entry after any byte already taken.
    assign notFull   = (count < FULL);
    assign dataPush  = bus.in_valid && bus.in_ready;
    assign tokenPush = flushPend && notFull;
    assign doPush    = dataPush || tokenPush;
    assign pushByte  = tokenPush ? END_TOKEN : bus.in_data;
    assign doPop     = (state == IDLE) && bus.sd_init_finish && (count != '0) && bus.fo_finish;

    assign bus.in_ready    = notFull && !flushPend;
    assign bus.busy        = (state != IDLE) || (count != '0) || flushPend;
    assign bus.overflow    = overflowReg;
    assign bus.block_count = blockCount;
    assign bus.fo_data     = foData;
    assign bus.fo_start    = foStart;

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushByte;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            count       <= '0;
            flushPend   <= 1'b0;
            overflowReg <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (tokenPush) begin
                flushPend <= 1'b0;
            end else if (bus.flush) begin
                flushPend <= 1'b1;
            end
            // A stalled producer during a pending flush is back-pressure, not data loss.
            if (bus.in_valid && !notFull && !flushPend) begin
                overflowReg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            foStart    <= 1'b0;
            foData     <= 8'h00;
            gapCnt     <= '0;
            blkIdx     <= '0;
            blockCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    foStart <= 1'b0;
                    if (doPop) begin
                        foData  <= mem[rdPtr];
                        foStart <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    foStart <= 1'b1;
                    if (!bus.fo_finish) begin
                        state <= ACK;
                    end
                end
                ACK: begin
                    foStart <= 1'b1;
                    if (bus.fo_finish) begin
                        foStart <= 1'b0;
                        gapCnt  <= '0;
                        state   <= REL;
                        // Same termination rule the writer applies, so both agree on block edges.
                        if ((foData == END_TOKEN) || (blkIdx == BLK_LAST)) begin
                            blockCount <= blockCount + 1'b1;
                            blkIdx     <= '0;
                        end else begin
                            blkIdx <= blkIdx + 1'b1;
                        end
                    end
                end
                REL: begin
                    foStart <= 1'b0;
                    if (gapCnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gapCnt <= gapCnt + 1'b1;
                    end
                end
                default: begin
                    foStart <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sd_byte_feeder.sv
// tb/tb_sd_byte_feeder.sv - randomized bench for sd_byte_feeder with writer model and byte-sequence scoreboard
module tb_sd_byte_feeder;
    localparam int         DEPTH      = 16;
    localparam int         GAP_CYCLES = 2;
    localparam int         BLOCK_LEN  = 512;
    localparam logic [7:0] END_TOKEN  = 8'h2D;

    logic clk;
    logic reset;

    sd_byte_feeder_if bus();

    sd_byte_feeder #(
        .DEPTH(DEPTH),
        .END_TOKEN(END_TOKEN),
        .BLOCK_MAX(BLOCK_LEN - 1),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: ordered list of bytes the writer must receive, and the block count they imply.
    logic [7:0] expQ[$];
    logic [7:0] gotQ[$];
    int expIdx    = 0;
    int expBlocks = 0;

    task automatic modelByte(input logic [7:0] b);
        expQ.push_back(b);
        if (b == END_TOKEN || expIdx == BLOCK_LEN - 1) begin
            expBlocks++;
            expIdx = 0;
        end else begin
            expIdx++;
        end
    endtask

    task automatic compareOut(input string tag);
        check({tag, ".len"}, 32'(gotQ.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            check(tag, 32'(gotQ[i]), 32'(expQ[i]));
        end
        expQ.delete();
        gotQ.delete();
    endtask

    // SD writer model: drops fo_finish ackDly cycles after seeing fo_start, raises it busyDly later.
    bit         writerHold = 1'b0;
    bit         randWriter = 1'b0;
    int         ackDly     = 1;
    int         busyDly    = 1;
    int         wPhase     = 0;
    int         wCnt       = 0;
    logic [7:0] wByte      = 8'h00;

    initial begin
        bus.fo_finish = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                wPhase        = 0;
                bus.fo_finish = !writerHold;
            end else begin
                case (wPhase)
                    0: begin
                        bus.fo_finish = !writerHold;
                        if (bus.fo_start && !writerHold) begin
                            wByte = bus.fo_data;
                            if (randWriter) begin
                                ackDly  = $urandom_range(1, 4);
                                busyDly = $urandom_range(1, 4);
                            end
                            wCnt   = ackDly;
                            wPhase = 1;
                        end
                    end
                    1, 2: begin
                        check("fo_start.held", 32'(bus.fo_start), 1);
                        check("fo_data.stable", 32'(bus.fo_data), 32'(wByte));
                        wCnt--;
                        if (wCnt == 0 && wPhase == 1) begin
                            bus.fo_finish = 1'b0;
                            wCnt          = busyDly;
                            wPhase        = 2;
                        end else if (wCnt == 0) begin
                            bus.fo_finish = 1'b1;
                            gotQ.push_back(wByte);
                            wPhase = 3;
                        end
                    end
                    default: begin
                        if (!bus.fo_start) begin
                            wPhase = 0;
                        end else begin
                            check("fo_data.stable", 32'(bus.fo_data), 32'(wByte));
                        end
                    end
                endcase
            end
        end
    end

    // Low time between back-to-back transfers: GAP_CYCLES in release plus one idle cycle.
    bit measureGaps = 1'b0;
    int lowRun      = 0;
    bit seenFall    = 1'b0;
    bit prevStart   = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                lowRun    = 0;
                seenFall  = 1'b0;
                prevStart = 1'b0;
            end else begin
                if (bus.fo_start && !prevStart && seenFall && measureGaps) begin
                    check("gap.low_cycles", 32'(lowRun), 32'(GAP_CYCLES + 1));
                end
                if (!bus.fo_start && prevStart) begin
                    seenFall = 1'b1;
                    lowRun   = 0;
                end
                if (!bus.fo_start) begin
                    lowRun++;
                end
                prevStart = bus.fo_start;
            end
        end
    end

    task automatic doReset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst.fo_start", 32'(bus.fo_start), 0);
        check("rst.fo_data", 32'(bus.fo_data), 0);
        check("rst.overflow", 32'(bus.overflow), 0);
        check("rst.block_count", 32'(bus.block_count), 0);
        check("rst.in_ready", 32'(bus.in_ready), 1);
        check("rst.busy", 32'(bus.busy), 0);
        reset = 1'b0;
        expQ.delete();
        gotQ.delete();
        expIdx    = 0;
        expBlocks = 0;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic expReady);
        check("in_ready", 32'(bus.in_ready), 32'(expReady));
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (expReady) begin
            modelByte(b);
        end
    endtask

    task automatic pulseFlush();
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        modelByte(END_TOKEN);
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        while ((bus.busy || wPhase != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".timeout"}, 32'(n >= budget), 0);
    endtask

    logic [7:0] rb;
    int         n;
    int         total;

    initial begin
        reset              = 1'b1;
        bus.in_valid       = 1'b0;
        bus.in_data        = 8'h00;
        bus.flush          = 1'b0;
        bus.sd_init_finish = 1'b0;

        // T1: single byte, fixed writer timing
        doReset();
        randWriter         = 1'b0;
        ackDly             = 3;
        busyDly            = 4;
        bus.sd_init_finish = 1'b1;
        sendByte(8'h41, 1'b1);
        @(negedge clk);
        check("t1.latency.fo_start", 32'(bus.fo_start), 1);
        check("t1.fo_data", 32'(bus.fo_data), 'h41);
        n = 0;
        while (bus.fo_start && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t1.fall.timeout", 32'(n >= 40), 0);
        check("t1.rel0.busy", 32'(bus.busy), 1);
        @(negedge clk);
        check("t1.rel1.busy", 32'(bus.busy), 1);
        check("t1.rel1.fo_start", 32'(bus.fo_start), 0);
        @(negedge clk);
        check("t1.idle.busy", 32'(bus.busy), 0);
        compareOut("t1.out");
        check("t1.block_count", 32'(bus.block_count), 32'(expBlocks));

        // T2: bytes wait for SD init, then drain in order
        doReset();
        randWriter         = 1'b1;
        bus.sd_init_finish = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sendByte(8'($urandom_range(0, 255)), 1'b1);
        end
        repeat (20) @(negedge clk);
        check("t2.noinit.fo_start", 32'(bus.fo_start), 0);
        check("t2.noinit.busy", 32'(bus.busy), 1);
        measureGaps        = 1'b1;
        bus.sd_init_finish = 1'b1;
        waitIdle("t2", 500);
        measureGaps = 1'b0;
        compareOut("t2.out");

        // T4: flush behaviour
        doReset();
        sendByte(8'h48, 1'b1);
        sendByte(8'h49, 1'b1);
        pulseFlush();
        waitIdle("t4a", 500);
        compareOut("t4a.out");
        check("t4a.block_count", 32'(bus.block_count), 32'(expBlocks));
        bus.flush = 1'b1;
        sendByte(8'h4A, 1'b1);
        bus.flush = 1'b0;
        modelByte(END_TOKEN);
        sendByte(8'h4B, 1'b0);
        check("t4b.stall.overflow", 32'(bus.overflow), 0);
        waitIdle("t4b", 500);
        compareOut("t4b.out");
        check("t4b.block_count", 32'(bus.block_count), 32'(expBlocks));
        sendByte(8'h4C, 1'b1);
        bus.flush = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        modelByte(END_TOKEN);
        waitIdle("t4c", 500);
        compareOut("t4c.out");
        check("t4c.block_count", 32'(bus.block_count), 32'(expBlocks));

        // T5: full 512-byte block without a token, then a flush
        doReset();
        total = 0;
        while (total < BLOCK_LEN - 1) begin
            n = $urandom_range(1, DEPTH);
            if (n > BLOCK_LEN - 1 - total) n = BLOCK_LEN - 1 - total;
            for (int i = 0; i < n; i++) begin
                rb = 8'($urandom_range(0, 255));
                if (rb == END_TOKEN) rb = 8'h2E;
                sendByte(rb, 1'b1);
            end
            waitIdle("t5.batch", 1000);
            total += n;
        end
        check("t5.511.block_count", 32'(bus.block_count), 0);
        sendByte(8'h5A, 1'b1);
        waitIdle("t5.512", 200);
        check("t5.512.block_count", 32'(bus.block_count), 1);
        pulseFlush();
        waitIdle("t5.flush", 200);
        check("t5.flush.block_count", 32'(bus.block_count), 2);
        check("t5.model.block_count", 32'(bus.block_count), 32'(expBlocks));
        compareOut("t5.out");

        // T3: fill with writer stalled, then overflow
        doReset();
        writerHold = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            sendByte(8'($urandom_range(0, 255)), 1'b1);
        end
        check("t3.full.in_ready", 32'(bus.in_ready), 0);
        check("t3.full.overflow", 32'(bus.overflow), 0);
        sendByte(8'h99, 1'b0);
        check("t3.overflow", 32'(bus.overflow), 1);
        writerHold = 1'b0;
        waitIdle("t3", 1000);
        compareOut("t3.out");
        check("t3.overflow.sticky", 32'(bus.overflow), 1);

        // T6: async reset while the writer holds the transfer in ACK
        randWriter = 1'b0;
        ackDly     = 1;
        busyDly    = 20;
        for (int i = 0; i < 3; i++) begin
            sendByte(8'($urandom_range(0, 255)), 1'b1);
        end
        n = 0;
        while (wPhase != 2 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("t6.ack.timeout", 32'(n >= 30), 0);
        @(negedge clk);
        @(negedge clk);
        check("t6.pre.fo_start", 32'(bus.fo_start), 1);
        #2 reset = 1'b1;
        #1;
        check("t6.async.fo_start", 32'(bus.fo_start), 0);
        check("t6.async.fo_data", 32'(bus.fo_data), 0);
        check("t6.async.busy", 32'(bus.busy), 0);
        check("t6.async.in_ready", 32'(bus.in_ready), 1);
        check("t6.async.overflow", 32'(bus.overflow), 0);
        check("t6.async.block_count", 32'(bus.block_count), 0);
        @(negedge clk);
        reset = 1'b0;
        expQ.delete();
        gotQ.delete();
        expIdx    = 0;
        expBlocks = 0;
        repeat (15) @(negedge clk);
        check("t6.post.fo_start", 32'(bus.fo_start), 0);
        check("t6.post.busy", 32'(bus.busy), 0);
        compareOut("t6.out");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", nChecks);
        $fatal(1, "watchdog");
    end
endmodule
